// File: rtl/dsack_controller.sv
// ---------------------------------------------------------------------------
// dsack_controller
//
// Bus-cycle terminator for the 68030 glue logic. Watches the address strobe
// and the decoder's one-hot device selects, counts a per-channel programmable
// number of wait states, honours a per-channel external hold, then drives the
// CPU DSACK code for the selected port width. A watchdog raises a bus error
// when a device never releases its hold. A malformed select (none or several
// bits set) is also terminated with a bus error.
//
// Ports:
//   clock          system clock, all state changes on the rising edge
//   reset          asynchronous active-high reset
//   as             address strobe, positive logic
//   cs             one-hot device selects, qualified by as
//   port_width     per-channel active-low DSACK code, channel i at [2i+1:2i]
//   ext_wait       per-channel device-not-ready hold, active-high
//   cfg_write      one-clock strobe loading wait[cfg_chan] <= cfg_wait
//   cfg_chan       channel to program
//   cfg_wait       wait count to load
//   n_dsack        registered CPU DSACK, active-low
//   berr           registered bus error, positive logic
//   busy           high whenever the FSM is not idle
//   timeout_event  one-clock pulse on a watchdog timeout
//   timeout_chan   channel latched at the most recent timeout
// ---------------------------------------------------------------------------
module dsack_controller #(
    parameter int CHANNELS       = 8,
    parameter int WAIT_WIDTH     = 4,
    parameter int TIMEOUT_WIDTH  = 8,
    parameter int TIMEOUT_CYCLES = 200,
    parameter int DEFAULT_WAIT   = 2
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        as,
    input  logic [CHANNELS-1:0]         cs,
    input  logic [2*CHANNELS-1:0]       port_width,
    input  logic [CHANNELS-1:0]         ext_wait,
    input  logic                        cfg_write,
    input  logic [$clog2(CHANNELS)-1:0] cfg_chan,
    input  logic [WAIT_WIDTH-1:0]       cfg_wait,
    output logic [1:0]                  n_dsack,
    output logic                        berr,
    output logic                        busy,
    output logic                        timeout_event,
    output logic [$clog2(CHANNELS)-1:0] timeout_chan
);

    localparam int CW = $clog2(CHANNELS);

    localparam logic [WAIT_WIDTH-1:0]    WAIT_RST  = WAIT_WIDTH'(DEFAULT_WAIT);
    localparam logic [WAIT_WIDTH-1:0]    WAIT_ZERO = {WAIT_WIDTH{1'b0}};
    localparam logic [WAIT_WIDTH-1:0]    WAIT_ONE  = WAIT_WIDTH'(1);
    localparam logic [TIMEOUT_WIDTH-1:0] TMO_ZERO  = {TIMEOUT_WIDTH{1'b0}};
    localparam logic [TIMEOUT_WIDTH-1:0] TMO_ONE   = TIMEOUT_WIDTH'(1);
    // Last WAIT edge that may still terminate normally; reaching it without
    // an acknowledge means the device has hung the bus.
    localparam logic [TIMEOUT_WIDTH-1:0] TMO_LAST  = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [CW:0]              CHAN_LIM  = CHANNELS[CW:0];
    localparam logic [CHANNELS-1:0]      CS_ONE    = CHANNELS'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_ACK  = 2'b10,
        ST_ERR  = 2'b11
    } state_t;

    // True when exactly one select bit is set.
    function automatic logic is_onehot(input logic [CHANNELS-1:0] v);
        return (v != {CHANNELS{1'b0}}) && ((v & (v - CS_ONE)) == {CHANNELS{1'b0}});
    endfunction

    // Index of the (highest) set bit; only meaningful for a one-hot vector.
    function automatic logic [CW-1:0] onehot_index(input logic [CHANNELS-1:0] v);
        logic [CW-1:0] idx;
        idx = {CW{1'b0}};
        for (int i = 0; i < CHANNELS; i++) begin
            if (v[i]) begin
                idx = CW'(i);
            end
        end
        return idx;
    endfunction

    logic [WAIT_WIDTH-1:0]    wait_r [CHANNELS];
    state_t                   state_r;
    logic [CW-1:0]            ch_r;
    logic [1:0]               pw_r;
    logic [WAIT_WIDTH-1:0]    cnt_r;
    logic [TIMEOUT_WIDTH-1:0] tmo_r;
    logic [1:0]               n_dsack_r;
    logic                     berr_r;
    logic                     busy_r;
    logic                     tev_r;
    logic [CW-1:0]            tchan_r;

    logic                     cs_valid_s;
    logic [CW-1:0]            cs_idx_s;
    logic [WAIT_WIDTH-1:0]    wait_sel_s;
    logic [1:0]               pw_sel_s;
    logic                     ack_now_s;
    logic                     tmo_hit_s;
    logic                     cfg_ok_s;

    // Decode of the incoming select and the per-cycle terminate conditions.
    always_comb begin
        cs_valid_s = is_onehot(cs);
        cs_idx_s   = onehot_index(cs);
        wait_sel_s = wait_r[cs_idx_s];
        pw_sel_s   = port_width[{cs_idx_s, 1'b0} +: 2];
        ack_now_s  = (cnt_r == WAIT_ZERO) && !ext_wait[ch_r];
        tmo_hit_s  = (tmo_r == TMO_LAST);
        cfg_ok_s   = ({1'b0, cfg_chan} < CHAN_LIM);
    end

    // Per-channel wait-count registers, written by the configuration strobe.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                wait_r[i] <= WAIT_RST;
            end
        end else if (cfg_write && cfg_ok_s) begin
            wait_r[cfg_chan] <= cfg_wait;
        end
    end

    // Bus-cycle state machine with registered DSACK/BERR/status outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            ch_r      <= {CW{1'b0}};
            pw_r      <= 2'b11;
            cnt_r     <= WAIT_ZERO;
            tmo_r     <= TMO_ZERO;
            n_dsack_r <= 2'b11;
            berr_r    <= 1'b0;
            busy_r    <= 1'b0;
            tev_r     <= 1'b0;
            tchan_r   <= {CW{1'b0}};
        end else begin
            tev_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (as) begin
                        busy_r <= 1'b1;
                        if (cs_valid_s) begin
                            // Select and port width are frozen here; later
                            // changes on cs/port_width do not matter.
                            ch_r    <= cs_idx_s;
                            pw_r    <= pw_sel_s;
                            cnt_r   <= wait_sel_s;
                            tmo_r   <= TMO_ZERO;
                            state_r <= ST_WAIT;
                        end else begin
                            // berr follows one edge later, from ST_ERR.
                            state_r <= ST_ERR;
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (!as) begin
                        // Aborted cycle: leave silently.
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else if (ack_now_s) begin
                        // Acknowledge takes priority over a coincident timeout.
                        state_r   <= ST_ACK;
                        n_dsack_r <= pw_r;
                    end else if (tmo_hit_s) begin
                        state_r <= ST_ERR;
                        berr_r  <= 1'b1;
                        tev_r   <= 1'b1;
                        tchan_r <= ch_r;
                    end else begin
                        if (cnt_r != WAIT_ZERO) begin
                            cnt_r <= cnt_r - WAIT_ONE;
                        end
                        tmo_r <= tmo_r + TMO_ONE;
                    end
                end
                ST_ACK: begin
                    if (!as) begin
                        state_r   <= ST_IDLE;
                        n_dsack_r <= 2'b11;
                        busy_r    <= 1'b0;
                    end
                end
                ST_ERR: begin
                    if (!as) begin
                        state_r <= ST_IDLE;
                        berr_r  <= 1'b0;
                        busy_r  <= 1'b0;
                    end else begin
                        berr_r <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    n_dsack_r <= 2'b11;
                    berr_r    <= 1'b0;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    assign n_dsack       = n_dsack_r;
    assign berr          = berr_r;
    assign busy          = busy_r;
    assign timeout_event = tev_r;
    assign timeout_chan  = tchan_r;

endmodule
